// File: rtl/week_4_vector_sweeper_pkg.sv
// ---------------------------------------------------------------------------
// week_4_pkg
// Shared constants for the Week 4 exhaustive vector sweeper:
//   - FSM state encodings (IDLE, SETTLE, SAMPLE, DONE)
//   - MISR feedback polynomial
//   - default input count and the resulting sweep length
// ---------------------------------------------------------------------------
package week_4_pkg;

  // FSM state encodings, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // CRC-16/CCITT polynomial used for the response signature
  localparam logic [15:0] POLY = 16'h1021;

  // Default drawing has seven inputs A..G
  localparam int DEF_N_IN  = 7;
  localparam int SWEEP_LEN = 1 << DEF_N_IN;

endpackage

// File: rtl/week_4_vector_sweeper_misr.sv
// ---------------------------------------------------------------------------
// week_4_misr
// Single-input MISR that folds one response bit per enabled cycle into a
// Galois-style shift signature.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, forces signature to zero
//   clear in   seeds the signature with all ones (start of a sweep)
//   en    in   fold din into the signature this cycle
//   din   in   response bit
//   sig   out  current signature
// ---------------------------------------------------------------------------
module week_4_misr #(
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  // One MISR step: shift left, apply feedback when the MSB falls out, xor input
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic             bit_in);
    logic [SIG_W-1:0] fb;
    fb = cur[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {cur[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, bit_in};
  endfunction

  // Signature register; reset beats clear, clear beats update
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= {SIG_W{1'b0}};
    end else if (clear) begin
      sig <= {SIG_W{1'b1}};
    end else if (en) begin
      sig <= misr_step(sig, din);
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/week_4_vector_sweeper.sv
// ---------------------------------------------------------------------------
// week_4_vector_sweeper
// Exhaustive stimulus generator and response checker for a 7-input
// combinational block. Walks every input vector, holds each for
// SETTLE_CYCLES, then samples DUT vs golden output for one cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a sweep (honoured only in IDLE or DONE)
//   vec                stimulus, vec[6]=A ... vec[0]=G
//   dut_y, ref_y       DUT output and golden-model output for vec
//   busy, done         sweep in progress / sweep finished (held)
//   pass_count         vectors where dut_y == ref_y
//   fail_count         vectors where dut_y != ref_y
//   first_fail_valid   a mismatch has been seen this sweep
//   first_fail_vec     vector of the first mismatch
//   signature          MISR of dut_y over the sweep
// ---------------------------------------------------------------------------
module week_4_vector_sweeper
  import week_4_pkg::*;
#(
  parameter int N_IN          = 7,
  parameter int SETTLE_CYCLES = 2,
  parameter int SIG_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic             dut_y,
  input  logic             ref_y,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    pass_count,
  output logic [N_IN:0]    fail_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [SIG_W-1:0] signature
);

  // Counter holds SETTLE_CYCLES-1 .. 0, so SETTLE lasts exactly SETTLE_CYCLES
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE     = {{N_IN{1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] settle_cnt;
  logic       start_ok;
  logic       sample_en;

  // start is only meaningful when no sweep is running
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign sample_en = (state == ST_SAMPLE);

  // Sweep FSM, vector generator and pass/fail bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      settle_cnt       <= 4'd0;
      vec              <= {N_IN{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_count       <= {(N_IN+1){1'b0}};
      fail_count       <= {(N_IN+1){1'b0}};
      first_fail_valid <= 1'b0;
      first_fail_vec   <= {N_IN{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state            <= ST_SETTLE;
            settle_cnt       <= SETTLE_LOAD;
            vec              <= {N_IN{1'b0}};
            busy             <= 1'b1;
            done             <= 1'b0;
            pass_count       <= {(N_IN+1){1'b0}};
            fail_count       <= {(N_IN+1){1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= {N_IN{1'b0}};
          end else begin
            state <= state;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (dut_y == ref_y) begin
            pass_count <= pass_count + CNT_ONE;
          end else begin
            fail_count <= fail_count + CNT_ONE;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end else begin
              first_fail_valid <= first_fail_valid;
            end
          end
          // The all-ones vector ends the sweep so vec never wraps
          if (vec == VEC_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec        <= vec + VEC_ONE;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  week_4_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(POLY))
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (sample_en),
    .din   (dut_y),
    .sig   (signature)
  );

endmodule

// File: tb/tb_week_4_vector_sweeper.sv
// Directed bench for week_4_vector_sweeper: clean, inverted, single-fault,
// ignored re-start, mid-sweep reset and restart-from-DONE sweeps.
module tb_week_4_vector_sweeper;
  import week_4_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  vec;
  logic        dut_y;
  logic        ref_y;
  logic        busy;
  logic        done;
  logic [7:0]  pass_count;
  logic [7:0]  fail_count;
  logic        first_fail_valid;
  logic [6:0]  first_fail_vec;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 clean, 1 inverted, 2 fault at 7'h5A
  int cyc;

  week_4_vector_sweeper dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vec              (vec),
    .dut_y            (dut_y),
    .ref_y            (ref_y),
    .busy             (busy),
    .done             (done),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .signature        (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden drawing: Y = A&B | (C^D) | (E & ~F & G)
  function automatic logic golden(input logic [6:0] v);
    return (v[6] & v[5]) | (v[4] ^ v[3]) | (v[2] & ~v[1] & v[0]);
  endfunction

  function automatic logic dut_model(input logic [6:0] v, input int m);
    logic g;
    g = golden(v);
    if (m == 1) return ~g;
    if (m == 2 && v == 7'h5A) return ~g;
    return g;
  endfunction

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    logic [6:0]  v;
    s = 16'hFFFF;
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, dut_model(v, m)};
    end
    return s;
  endfunction

  assign ref_y = golden(vec);
  assign dut_y = dut_model(vec, mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"},  vec, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass_count, 0);
    chk({tag, "_fail"}, fail_count, 0);
    chk({tag, "_ffv"},  first_fail_valid, 0);
    chk({tag, "_ffvec"}, first_fail_vec, 0);
    chk({tag, "_sig"},  signature, 0);
  endtask

  // Pulse start, check the start-edge clear, then run until done (bounded).
  task automatic run_sweep(input int repulse, input int rst_at, input int hold_chk);
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_done_low", done, 0);
    chk("start_busy",     busy, 1);
    chk("start_pass_clr", pass_count, 0);
    chk("start_fail_clr", fail_count, 0);
    chk("start_ffv_clr",  first_fail_valid, 0);
    chk("start_sig_seed", signature, 16'hFFFF);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (repulse != 0) && (cyc == 10 || cyc == 50);
      if (hold_chk != 0 && cyc < 384) chk("vec_hold", vec, cyc / 3);
      if (rst_at != 0 && cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("midrst");
        return;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_time", cyc, 384);
    chk("end_busy", busy, 0);
    chk("end_vec", vec, 7'h7F);
    chk("end_total", pass_count + fail_count, SWEEP_LEN);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    // start while in reset must not begin a sweep
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_over_start", busy, 0);

    // Clean sweep
    mode = 0;
    run_sweep(0, 0, 0);
    chk("clean_pass", pass_count, 128);
    chk("clean_fail", fail_count, 0);
    chk("clean_ffv",  first_fail_valid, 0);
    chk("clean_ffvec", first_fail_vec, 0);
    chk("clean_sig",  signature, model_sig(0));
    // results frozen in DONE
    repeat (5) @(posedge clk);
    #1;
    chk("done_held", done, 1);
    chk("done_frozen_pass", pass_count, 128);

    // Inverted DUT, started from DONE
    mode = 1;
    run_sweep(0, 0, 0);
    chk("inv_pass", pass_count, 0);
    chk("inv_fail", fail_count, 128);
    chk("inv_ffv",  first_fail_valid, 1);
    chk("inv_ffvec", first_fail_vec, 7'h00);
    chk("inv_sig",  signature, model_sig(1));

    // Single fault at 7'h5A, with per-cycle vector hold checks
    mode = 2;
    run_sweep(0, 0, 1);
    chk("flt_pass", pass_count, 127);
    chk("flt_fail", fail_count, 1);
    chk("flt_ffv",  first_fail_valid, 1);
    chk("flt_ffvec", first_fail_vec, 7'h5A);
    chk("flt_sig",  signature, model_sig(2));

    // Restart from DONE after a fault run: clean second sweep
    mode = 0;
    run_sweep(0, 0, 0);
    chk("rerun_fail", fail_count, 0);
    chk("rerun_pass", pass_count, 128);
    chk("rerun_ffv",  first_fail_valid, 0);

    // start re-pulsed at cycles 10 and 50 is ignored
    run_sweep(1, 0, 0);
    chk("repulse_pass", pass_count, 128);
    chk("repulse_fail", fail_count, 0);
    chk("repulse_sig",  signature, model_sig(0));

    // Reset at cycle 100, stays idle, then a full sweep
    run_sweep(0, 100, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_vec",  vec, 0);
    chk("idle_sig",  signature, 0);
    run_sweep(0, 0, 0);
    chk("post_rst_pass", pass_count, 128);
    chk("post_rst_sig",  signature, model_sig(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
